// File: rtl/uart_transmitter.sv
// uart_transmitter: UART transmitter with a FIFO_DEPTH-entry input byte buffer.
// Frame: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts
// CLOCK_FREQ/BAUD_RATE clock cycles.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bit.
module uart_transmitter #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out,
    output logic       busy
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CW               = $clog2(SYMBOL_EDGE_TIME + 1);
    localparam int AW               = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_LAST   = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_byte;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;

    logic fifo_empty;
    logic bit_end;
    logic push;
    logic pop;

    // Handshake, pop decision and next buffer occupancy.
    always_comb begin
        fifo_empty = (count == '0);
        bit_end    = (bit_cnt == CNT_LAST);
        push       = data_in_valid && data_in_ready;
        pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
        busy       = (state != IDLE) || !fifo_empty;
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    // Buffer storage; pointers are guarded by reset so stale entries are unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Buffer pointers, occupancy and registered ready (not full after this edge).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            data_in_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count         <= count_next;
            data_in_ready <= (count_next != FULL_COUNT);
        end
    end

    // Frame sequencer: the line value for the next bit is registered at each bit boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift_byte <= '0;
            serial_out <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (pop) begin
                        state      <= START;
                        shift_byte <= mem[rd_ptr];
                        serial_out <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt    <= '0;
                        bit_idx    <= '0;
                        serial_out <= shift_byte[0];
                        state      <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state      <= PARITY;
                            serial_out <= ^shift_byte;
`else
                            state      <= STOP;
                            serial_out <= 1'b1;
`endif
                        end else begin
                            serial_out <= shift_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        bit_cnt    <= '0;
                        state      <= STOP;
                        serial_out <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (pop) begin
                            state      <= START;
                            shift_byte <= mem[rd_ptr];
                            serial_out <= 1'b0;
                        end else begin
                            state      <= IDLE;
                            serial_out <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    bit_cnt    <= '0;
                    serial_out <= 1'b1;
                end
            endcase
        end
    end

endmodule
